// File: rtl/ascon_permutation.sv
// ****************************************************************************
// * ascon_permutation -- iterative ASCON p^a/p^b core, UNROLL rounds/clock
// * Optional: ASCON_PERM_ABORT_EN adds an abort input.   Rev 1.0
// ****************************************************************************
`default_nettype none

module ascon_permutation #(
   parameter int UNROLL = 1
) (
   input  logic         clk,
   input  logic         rst_n,
`ifdef ASCON_PERM_ABORT_EN
   input  logic         abort,
`endif
   input  logic         in_valid,
   output logic         in_ready,
   input  logic [319:0] state_in,
   input  logic [3:0]   nr,
   output logic         out_valid,
   input  logic         out_ready,
   output logic [319:0] state_out
);

   generate
      if (UNROLL != 1 && UNROLL != 2) begin : g_bad_unroll
         $error("ascon_permutation: UNROLL must be 1 or 2");
      end
   endgenerate

   localparam logic [3:0] STEP = 4'(UNROLL);

   typedef enum logic [1:0] {IDLE, RUN, DONE} state_e;

   state_e         fsm_q, fsm_d;
   logic [319:0]   st_q, st_d;
   logic [3:0]     rnd_q, rnd_d;
   logic [319:0]   round_out;

   function automatic logic [319:0] ascon_round(input logic [319:0] s, input logic [3:0] i);
      logic [63:0] x0, x1, x2, x3, x4;
      logic [63:0] t0, t1, t2, t3, t4;
      x0 = s[319:256];
      x1 = s[255:192];
      x2 = s[191:128] ^ {56'd0, 4'hF - i, i};
      x3 = s[127:64];
      x4 = s[63:0];
      // bit-sliced S-box across all 64 columns
      x0 = x0 ^ x4;  x4 = x4 ^ x3;  x2 = x2 ^ x1;
      t0 = ~x0 & x1; t1 = ~x1 & x2; t2 = ~x2 & x3; t3 = ~x3 & x4; t4 = ~x4 & x0;
      x0 = x0 ^ t1;  x1 = x1 ^ t2;  x2 = x2 ^ t3;  x3 = x3 ^ t4;  x4 = x4 ^ t0;
      x1 = x1 ^ x0;  x0 = x0 ^ x4;  x3 = x3 ^ x2;  x2 = ~x2;
      x0 = x0 ^ {x0[18:0], x0[63:19]} ^ {x0[27:0], x0[63:28]};
      x1 = x1 ^ {x1[60:0], x1[63:61]} ^ {x1[38:0], x1[63:39]};
      x2 = x2 ^ {x2[0],    x2[63:1]}  ^ {x2[5:0],  x2[63:6]};
      x3 = x3 ^ {x3[9:0],  x3[63:10]} ^ {x3[16:0], x3[63:17]};
      x4 = x4 ^ {x4[6:0],  x4[63:7]}  ^ {x4[40:0], x4[63:41]};
      return {x0, x1, x2, x3, x4};
   endfunction

   generate
      if (UNROLL == 2) begin : g_unroll2
         assign round_out = ascon_round(ascon_round(st_q, rnd_q), rnd_q + 4'd1);
      end else begin : g_unroll1
         assign round_out = ascon_round(st_q, rnd_q);
      end
   endgenerate

   always_comb begin
      fsm_d = fsm_q;
      st_d  = st_q;
      rnd_d = rnd_q;
      unique case (fsm_q)
         IDLE: begin
            if (in_valid) begin
               st_d  = state_in;
               fsm_d = RUN;
               // unsupported round counts fall back to the full p^12
               case (nr)
                  4'd6:    rnd_d = 4'd6;
                  4'd8:    rnd_d = 4'd4;
                  default: rnd_d = 4'd0;
               endcase
            end
         end
         RUN: begin
            st_d  = round_out;
            rnd_d = rnd_q + STEP;
            if (rnd_q + STEP == 4'd12) fsm_d = DONE;
         end
         DONE: begin
            if (out_ready) fsm_d = IDLE;
         end
         default: fsm_d = IDLE;
      endcase
`ifdef ASCON_PERM_ABORT_EN
      if (abort) begin
         fsm_d = IDLE;
         st_d  = '0;
         rnd_d = '0;
      end
`endif
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         fsm_q <= IDLE;
         st_q  <= '0;
         rnd_q <= '0;
      end else begin
         fsm_q <= fsm_d;
         st_q  <= st_d;
         rnd_q <= rnd_d;
      end
   end

   assign in_ready  = (fsm_q == IDLE);
   assign out_valid = (fsm_q == DONE);
   assign state_out = st_q;

endmodule

`default_nettype wire

// File: tb/tb_ascon_permutation.sv
// Self-checking bench for ascon_permutation: UNROLL=1 and UNROLL=2 instances
// checked against a table-driven reference permutation through a scoreboard.
`default_nettype none

module tb_ascon_permutation;

   logic         clk = 1'b0;
   logic         rst_n;
   logic         in_valid  [2];
   logic [319:0] state_in  [2];
   logic [3:0]   nr        [2];
   logic         out_ready [2];
   logic         in_ready  [2];
   logic         out_valid [2];
   logic [319:0] state_out [2];
`ifdef ASCON_PERM_ABORT_EN
   logic         abort     [2];
`endif

   int n_checks = 0;
   int n_pass   = 0;
   logic [319:0] exp_q[$];
   int           lat_q[$];

   always #5 clk = ~clk;

   ascon_permutation #(.UNROLL(1)) u_dut1 (
      .clk(clk), .rst_n(rst_n),
`ifdef ASCON_PERM_ABORT_EN
      .abort(abort[0]),
`endif
      .in_valid(in_valid[0]), .in_ready(in_ready[0]), .state_in(state_in[0]), .nr(nr[0]),
      .out_valid(out_valid[0]), .out_ready(out_ready[0]), .state_out(state_out[0])
   );

   ascon_permutation #(.UNROLL(2)) u_dut2 (
      .clk(clk), .rst_n(rst_n),
`ifdef ASCON_PERM_ABORT_EN
      .abort(abort[1]),
`endif
      .in_valid(in_valid[1]), .in_ready(in_ready[1]), .state_in(state_in[1]), .nr(nr[1]),
      .out_valid(out_valid[1]), .out_ready(out_ready[1]), .state_out(state_out[1])
   );

   // reference S-box, input {x0,x1,x2,x3,x4} with x0 as MSB
   logic [4:0] sbox_tbl [32] = '{5'h04, 5'h0b, 5'h1f, 5'h14, 5'h1a, 5'h15, 5'h09, 5'h02,
                                 5'h1b, 5'h05, 5'h08, 5'h12, 5'h1d, 5'h03, 5'h06, 5'h1c,
                                 5'h1e, 5'h13, 5'h07, 5'h0e, 5'h00, 5'h0d, 5'h11, 5'h18,
                                 5'h10, 5'h0c, 5'h01, 5'h19, 5'h16, 5'h0a, 5'h0f, 5'h17};

   function automatic logic [63:0] rr(input logic [63:0] x, input int n);
      return (x >> n) | (x << (64 - n));
   endfunction

   function automatic logic [319:0] g_round(input logic [319:0] s, input int i);
      logic [63:0] x [5];
      logic [63:0] y [5];
      logic [4:0]  col, o;
      logic [7:0]  c;
      for (int k = 0; k < 5; k++) x[k] = s[319 - 64*k -: 64];
      c = 8'(((15 - i) << 4) | i);
      x[2][7:0] = x[2][7:0] ^ c;
      for (int j = 0; j < 64; j++) begin
         col = {x[0][j], x[1][j], x[2][j], x[3][j], x[4][j]};
         o = sbox_tbl[col];
         y[0][j] = o[4]; y[1][j] = o[3]; y[2][j] = o[2]; y[3][j] = o[1]; y[4][j] = o[0];
      end
      x[0] = y[0] ^ rr(y[0], 19) ^ rr(y[0], 28);
      x[1] = y[1] ^ rr(y[1], 61) ^ rr(y[1], 39);
      x[2] = y[2] ^ rr(y[2], 1)  ^ rr(y[2], 6);
      x[3] = y[3] ^ rr(y[3], 10) ^ rr(y[3], 17);
      x[4] = y[4] ^ rr(y[4], 7)  ^ rr(y[4], 41);
      return {x[0], x[1], x[2], x[3], x[4]};
   endfunction

   function automatic logic [319:0] g_perm(input logic [319:0] s, input int rounds);
      logic [319:0] r = s;
      for (int i = 12 - rounds; i < 12; i++) r = g_round(r, i);
      return r;
   endfunction

   function automatic logic [319:0] rand320();
      logic [319:0] r;
      for (int k = 0; k < 10; k++) r[32*k +: 32] = $urandom;
      return r;
   endfunction

   // Called #1 after an edge with DUT u idle; accepts on the following edge.
   task automatic start_job(input int u, input logic [319:0] s, input logic [3:0] n,
                            input logic [319:0] e, input int lat);
      in_valid[u] = 1'b1;
      state_in[u] = s;
      nr[u]       = n;
      exp_q.push_back(e);
      lat_q.push_back(lat);
      @(posedge clk); #1;
      in_valid[u] = 1'b0;
      state_in[u] = rand320();
      nr[u]       = 4'd6;
      n_checks++;
      if (state_out[u] !== s || in_ready[u] !== 1'b0)
         $display("FAIL load u%0d: state_out=%h in_ready=%b, expected %h in_ready=0",
                  u, state_out[u], in_ready[u], s);
      else n_pass++;
   endtask

   task automatic wait_result(input int u, input int start_cyc, input string tag);
      int cyc = start_cyc;
      bit rdy_seen = 1'b0;
      logic [319:0] e;
      int l;
      while (out_valid[u] !== 1'b1 && cyc < 40) begin
         if (in_ready[u] !== 1'b0) rdy_seen = 1'b1;
         @(posedge clk); #1;
         cyc++;
      end
      e = exp_q.pop_front();
      l = lat_q.pop_front();
      n_checks++;
      if (cyc != l) $display("FAIL %s latency: got %0d cycles, expected %0d", tag, cyc, l);
      else n_pass++;
      n_checks++;
      if (state_out[u] !== e) $display("FAIL %s result: got %h expected %h", tag, state_out[u], e);
      else n_pass++;
      n_checks++;
      if (rdy_seen || in_ready[u] !== 1'b0)
         $display("FAIL %s in_ready busy: got high during RUN/DONE, expected 0", tag);
      else n_pass++;
   endtask

   task automatic release_job(input int u, input string tag);
      out_ready[u] = 1'b1;
      @(posedge clk); #1;
      out_ready[u] = 1'b0;
      n_checks++;
      if ({out_valid[u], in_ready[u]} !== 2'b01)
         $display("FAIL %s release: out_valid,in_ready=%b expected 01", tag, {out_valid[u], in_ready[u]});
      else n_pass++;
   endtask

   task automatic test_reset();
      rst_n = 1'b0;
      for (int u = 0; u < 2; u++) begin
         in_valid[u] = 1'b1; state_in[u] = rand320(); nr[u] = 4'($urandom);
         out_ready[u] = 1'($urandom);
`ifdef ASCON_PERM_ABORT_EN
         abort[u] = 1'b0;
`endif
      end
      #2;
      repeat (2) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         n_checks++;
         if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0 || state_out[u] !== 320'h0)
            $display("FAIL reset u%0d: in_ready=%b out_valid=%b state_out=%h, expected 1 0 0",
                     u, in_ready[u], out_valid[u], state_out[u]);
         else n_pass++;
         in_valid[u] = 1'b0; out_ready[u] = 1'b0;
      end
      @(negedge clk); rst_n = 1'b1;
      repeat (3) @(posedge clk);
      #1;
      for (int u = 0; u < 2; u++) begin
         n_checks++;
         if (in_ready[u] !== 1'b1 || out_valid[u] !== 1'b0 || state_out[u] !== 320'h0)
            $display("FAIL post-reset u%0d: in_ready=%b out_valid=%b state_out=%h, expected 1 0 0",
                     u, in_ready[u], out_valid[u], state_out[u]);
         else n_pass++;
      end
   endtask

   task automatic test_latency();
      start_job(0, 320'h0, 4'd12, g_perm(320'h0, 12), 12);
      wait_result(0, 0, "p12_zero");
      release_job(0, "p12_zero");
   endtask

   task automatic test_round_constants();
      int rl [3] = '{6, 8, 12};
      logic [319:0] s;
      for (int k = 0; k < 3; k++) begin
         s = rand320();
         start_job(0, s, 4'(rl[k]), g_perm(s, rl[k]), rl[k]);
         @(posedge clk); #1;
         n_checks++;
         if (state_out[0] !== g_round(s, 12 - rl[k]))
            $display("FAIL first_round nr=%0d: got %h expected %h", rl[k], state_out[0], g_round(s, 12 - rl[k]));
         else n_pass++;
         wait_result(0, 1, "rc");
         release_job(0, "rc");
      end
   endtask

   task automatic test_backpressure();
      logic [319:0] s = rand320();
      logic [319:0] s2 = rand320();
      logic [319:0] e = g_perm(s, 6);
      start_job(0, s, 4'd6, e, 6);
      wait_result(0, 0, "bp");
      in_valid[0] = 1'b1;
      state_in[0] = s2;
      nr[0]       = 4'd8;
      exp_q.push_back(g_perm(s2, 8));
      lat_q.push_back(8);
      for (int c = 0; c < 5; c++) begin
         @(posedge clk); #1;
         n_checks++;
         if (out_valid[0] !== 1'b1 || in_ready[0] !== 1'b0 || state_out[0] !== e)
            $display("FAIL bp hold c%0d: out_valid=%b in_ready=%b state_out=%h expected 1 0 %h",
                     c, out_valid[0], in_ready[0], state_out[0], e);
         else n_pass++;
      end
      release_job(0, "bp");
      @(posedge clk); #1;
      in_valid[0] = 1'b0;
      n_checks++;
      if (in_ready[0] !== 1'b0 || state_out[0] !== s2)
         $display("FAIL bp reaccept: in_ready=%b state_out=%h expected 0 %h", in_ready[0], state_out[0], s2);
      else n_pass++;
      wait_result(0, 0, "bp_next");
      release_job(0, "bp_next");
   endtask

   task automatic test_unroll_illegal();
      logic [319:0] s;
      s = rand320();
      start_job(1, s, 4'd8, g_perm(s, 8), 4);
      wait_result(1, 0, "u2_p8");
      release_job(1, "u2_p8");
      s = rand320();
      start_job(1, s, 4'd6, g_perm(s, 6), 3);
      wait_result(1, 0, "u2_p6");
      release_job(1, "u2_p6");
      s = rand320();
      start_job(1, s, 4'd5, g_perm(s, 12), 6);
      wait_result(1, 0, "u2_nr5");
      release_job(1, "u2_nr5");
      s = rand320();
      start_job(0, s, 4'd15, g_perm(s, 12), 12);
      wait_result(0, 0, "u1_nr15");
      release_job(0, "u1_nr15");
   endtask

   task automatic test_reset_mid_run();
      logic [319:0] s = rand320();
      bit seen_valid = 1'b0;
      start_job(0, s, 4'd12, g_perm(s, 12), 12);
      repeat (2) @(posedge clk);
      #1;
      rst_n = 1'b0;
      #1;
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      n_checks++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || state_out[0] !== 320'h0)
         $display("FAIL mid_reset: in_ready=%b out_valid=%b state_out=%h expected 1 0 0",
                  in_ready[0], out_valid[0], state_out[0]);
      else n_pass++;
      repeat (2) @(posedge clk);
      @(negedge clk); rst_n = 1'b1;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (out_valid[0] !== 1'b0) seen_valid = 1'b1;
      end
      n_checks++;
      if (seen_valid) $display("FAIL mid_reset no_output: got out_valid=1, expected 0");
      else n_pass++;
      s = rand320();
      start_job(0, s, 4'd8, g_perm(s, 8), 8);
      wait_result(0, 0, "after_reset");
      release_job(0, "after_reset");
   endtask

`ifdef ASCON_PERM_ABORT_EN
   task automatic test_abort();
      logic [319:0] s = rand320();
      bit seen_valid = 1'b0;
      start_job(0, s, 4'd12, g_perm(s, 12), 12);
      void'(exp_q.pop_front());
      void'(lat_q.pop_front());
      repeat (2) @(posedge clk);
      #1;
      abort[0] = 1'b1;
      @(posedge clk); #1;
      n_checks++;
      if (in_ready[0] !== 1'b1 || out_valid[0] !== 1'b0 || state_out[0] !== 320'h0)
         $display("FAIL abort: in_ready=%b out_valid=%b state_out=%h expected 1 0 0",
                  in_ready[0], out_valid[0], state_out[0]);
      else n_pass++;
      in_valid[0] = 1'b1;
      state_in[0] = rand320();
      @(posedge clk); #1;
      n_checks++;
      if (in_ready[0] !== 1'b1 || state_out[0] !== 320'h0)
         $display("FAIL abort_idle: in_ready=%b state_out=%h expected 1 0", in_ready[0], state_out[0]);
      else n_pass++;
      in_valid[0] = 1'b0;
      abort[0]    = 1'b0;
      for (int c = 0; c < 12; c++) begin
         @(posedge clk); #1;
         if (out_valid[0] !== 1'b0) seen_valid = 1'b1;
      end
      n_checks++;
      if (seen_valid) $display("FAIL abort no_output: got out_valid=1, expected 0");
      else n_pass++;
      s = rand320();
      start_job(0, s, 4'd6, g_perm(s, 6), 6);
      wait_result(0, 0, "after_abort");
      release_job(0, "after_abort");
   endtask
`endif

   initial begin
      test_reset();
      @(posedge clk); #1;
      test_latency();
      test_round_constants();
      test_backpressure();
      test_unroll_illegal();
      test_reset_mid_run();
`ifdef ASCON_PERM_ABORT_EN
      test_abort();
`endif
      $display("%0d/%0d checks passed", n_pass, n_checks);
      $finish;
   end

endmodule

`default_nettype wire
